// File: rtl/pokey_irq_stat.sv
// POKEY interrupt/serial-status block: latches serial, keyboard and timer events
// into IRQST/SKSTAT, applies the IRQEN mask and drives the CPU interrupt line.
module pokey_irq_stat (
    input  logic       clk,
    input  logic       reset,
    input  logic       enn,
    input  logic       enp,
    input  logic [7:0] Dw,
    input  logic       AddrEw,
    input  logic       AddrAw,
    input  logic       setFramerr,
    input  logic       setSdiCompl,
    input  logic       setSdoCompl,
    input  logic       sdoFinish,
    input  logic       sdiBusy,
    input  logic       SID,
    input  logic [2:0] Timer,
    input  logic       keyIrq,
    input  logic       keyOvrIn,
    input  logic       breakKey,
    input  logic       keyDown,
    input  logic       shiftDown,
    output logic [7:0] IRQST,
    output logic [7:0] SKSTAT,
    output logic [7:0] IRQEN,
    output logic       IRQ_n
);

    logic [7:0] r_irqen;
    logic [7:0] r_pend;      // bit 3 is never latched; it stays 0
    logic       r_fe;
    logic       r_sov;
    logic       r_kov;
    logic       r_sidr;

    logic [7:0] w_src;
    logic [7:0] w_set;
    logic [7:0] w_keep;
    logic [7:0] w_pend_next;
    logic [7:0] w_pend_vis;
    logic       w_irqen_wr;
    logic       w_skres;
    logic       w_fe_set;
    logic       w_sov_set;
    logic       w_kov_set;

    assign w_src      = {breakKey, keyIrq, setSdiCompl, setSdoCompl, 1'b0, Timer};
    assign w_irqen_wr = enp & AddrEw;
    assign w_skres    = enp & AddrAw;

    // Events only latch through the enable mask already registered.
    assign w_set       = enn ? (w_src & r_irqen) : 8'h00;
    assign w_keep      = w_irqen_wr ? Dw : 8'hFF;
    assign w_pend_next = (r_pend | w_set) & w_keep & 8'hF7;

    // Overrun detection looks at the pending state before this event lands.
    assign w_fe_set  = enn & setFramerr;
    assign w_sov_set = enn & setSdiCompl & r_pend[5];
    assign w_kov_set = enn & ((keyIrq & r_pend[6]) | keyOvrIn);

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values of its neighbours, regardless of statement order.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_irqen <= 8'h00;
            r_pend  <= 8'h00;
            r_fe    <= 1'b0;
            r_sov   <= 1'b0;
            r_kov   <= 1'b0;
            r_sidr  <= 1'b1;
        end else begin
            if (w_irqen_wr) begin
                r_irqen <= Dw;
            end
            r_pend <= w_pend_next;
            r_fe   <= w_fe_set  | (r_fe  & ~w_skres);
            r_sov  <= w_sov_set | (r_sov & ~w_skres);
            r_kov  <= w_kov_set | (r_kov & ~w_skres);
            if (enn) begin
                r_sidr <= SID;
            end
        end
    end

    assign w_pend_vis = r_pend | {4'b0000, sdoFinish & r_irqen[3], 3'b000};
    assign IRQST      = ~w_pend_vis;
    assign IRQ_n      = ~|w_pend_vis;
    assign IRQEN      = r_irqen;
    assign SKSTAT     = {~r_fe, ~r_kov, ~r_sov, r_sidr, ~shiftDown, ~keyDown, ~sdiBusy, 1'b1};

endmodule

// File: doc/pokey_irq_stat.md
# pokey_irq_stat

Interrupt and serial-status register block for the POKEY core. Sits directly downstream of the serial core (SER_core) and the frequency-control timers. Latches serial completion, error and timer-underflow events into the IRQST and SKSTAT read registers, applies the IRQEN mask, and drives the CPU interrupt line. Register writes are taken from the bus on `enp` strobes; events are sampled on `enn` strobes of the 1.79 MHz phase.

## Interface
Parameters: none.

Ports:
- `clk`  in  1  system clock (50 MHz); all state is on `posedge clk`.
- `reset`  in  1  asynchronous, active-high reset.
- `enn`  in  1  1.79 MHz falling-phase strobe, one `clk` wide; qualifies event sampling.
- `enp`  in  1  1.79 MHz rising-phase strobe, one `clk` wide; qualifies register writes.
- `Dw`  in  8  write data bus.
- `AddrEw`  in  1  IRQEN write select ($0E).
- `AddrAw`  in  1  SKRES write select ($0A).
- `setFramerr`  in  1  framing-error pulse from SER_core.
- `setSdiCompl`  in  1  serial-input-byte-complete pulse.
- `setSdoCompl`  in  1  serial-output-register-empty pulse (transmit "needed").
- `sdoFinish`  in  1  level: serial output shifter idle.
- `sdiBusy`  in  1  level: receive in progress.
- `SID`  in  1  raw serial data input.
- `Timer`  in  3  underflow pulses `{T4, T2, T1}`.
- `keyIrq`, `keyOvrIn`, `breakKey`  in  1 each  keyboard event pulses.
- `keyDown`, `shiftDown`  in  1 each  keyboard levels.
- `IRQST`  out  8  interrupt status, active-low.
- `SKSTAT`  out  8  serial/keyboard status, active-low.
- `IRQEN`  out  8  current enable mask (readback for debug).
- `IRQ_n`  out  1  CPU interrupt, active-low.

## Operation
- Pending latches `P[7:0]`, excluding bit 3. Sources:
  - b7 `breakKey`, b6 `keyIrq`, b5 `setSdiCompl`, b4 `setSdoCompl`.
  - b2 `Timer[T4]`, b1 `Timer[T2]`, b0 `Timer[T1]`.
- A latch sets on a `clk` where `enn=1`, its source is 1, and the matching `IRQEN` bit is 1. It holds until cleared.
- IRQEN write (`enp & AddrEw`): `IRQEN <= Dw`. Every bit written 0 clears its pending latch in the same cycle. A latch whose enable is 0 is held clear.
- `IRQST = ~{P[7:4], sdoFinish & IRQEN[3], P[2:0]}`.
  - Bit 3 is not latched; it tracks `sdoFinish` gated by `IRQEN[3]`.
- `IRQ_n = ~|(~IRQST)`.
- Error latches, set on `enn`:
  - `FE` on `setFramerr`.
  - `SOV` on `setSdiCompl` while `P[5]=1` (previous byte not yet acknowledged).
  - `KOV` on `keyIrq` while `P[6]=1`, or on `keyOvrIn`.
- SKRES write (`enp & AddrAw`) clears `FE`, `SOV` and `KOV`; `Dw` is ignored.
- `SIDr` is a register loaded from `SID` on every `enn`.
- `SKSTAT = {~FE, ~KOV, ~SOV, SIDr, ~shiftDown, ~keyDown, ~sdiBusy, 1'b1}`.
- Precedence and boundary rules:
  - Set wins over SKRES clear in the same cycle.
  - An event on an `enn` cycle uses the IRQEN value already registered. Writes land on `enp` and never coincide with `enn`.
  - An event arriving while its latch is already set leaves the latch set. Only the SOV/KOV overrun logic observes the repeat.
  - Reset mid-byte: all latches and IRQEN clear immediately. SER_core events after reset are treated as fresh.

## Timing
- Reset values:
  - `IRQEN=8'h00`, all `P`, `FE`, `SOV`, `KOV` = 0, `SIDr=1`.
  - `IRQST=8'hFF`, `IRQ_n=1`.
  - `SKSTAT = {1,1,1,1,~shiftDown,~keyDown,~sdiBusy,1}`.
- Event to `IRQST` / `IRQ_n` latency: 1 `clk` after the `enn` cycle that samples it. Outputs are combinational from the latches.
- IRQEN write to latch clear: visible 1 `clk` after the `enp` cycle.
- `IRQST[3]` and `SKSTAT[3:1]` follow their inputs combinationally, with 0 latency.
- No handshake: the consumer acknowledges by writing IRQEN (disable, then re-enable).

## Test plan
- Reset with `sdoFinish=1`, `sdiBusy=0`, `keyDown=0`, `shiftDown=0`, `SID=1` -> `IRQST=FF`, `SKSTAT=FF`, `IRQ_n=1`.
- `IRQEN=8'h20`, one `setSdiCompl` -> `IRQST=DF`, `IRQ_n=0`. Write `IRQEN=00` -> `IRQST=FF`, `IRQ_n=1`.
- `IRQEN=20`, two `setSdiCompl` with no acknowledge -> `SKSTAT[5]=0`. SKRES write -> `SKSTAT[5]=1` while `IRQST[5]` stays 0.
- `setFramerr` pulse on the same `clk` as an SKRES write -> `SKSTAT[7]=0`, i.e. set wins.
- `IRQEN=08`, toggle `sdoFinish` 0/1 -> `IRQST` alternates `FF`/`F7` with no latching; `IRQEN=00` -> `FF`.
- `IRQEN=07`, pulses on `Timer` `{T4,T2,T1}` in turn -> `IRQST` `FE`, `FC`, `F8`. Assert `reset` -> `FF` on the same `clk` edge.
